// File: rtl/bomb_launcher.sv
// bomb_launcher: turns a bouncing player drop button into bomb placement
// requests for the bomb-map engine.
//
// Handshake: bomb_v is a registered request that stays high, with bomb_x and
// bomb_y held steady, until the engine samples it. The engine signals this
// by asserting bomb_tick for one clk cycle. A bomb_tick that arrives while
// bomb_v is high completes the request. After that the player is locked out
// for COOLDOWN_TICKS further ticks. A bomb_tick while bomb_v is low has no
// meaning for the request.
module bomb_launcher #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [2:0]  COOLDOWN_TICKS  = 3'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       bomb_tick,
  input  logic [3:0] player_x,
  input  logic [3:0] player_y,
  input  logic [1:0] game_state,
  output logic       bomb_v,
  output logic [3:0] bomb_x,
  output logic [3:0] bomb_y,
  output logic       busy,
  output logic [7:0] launch_count,
  output logic [1:0] dbgState
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COOLDOWN = 2'd2
  } stateT;

  // A zero-cycle debounce degenerates to a single stable cycle.
  localparam logic [19:0] DB_LIMIT =
    (DEBOUNCE_CYCLES == 20'd0) ? 20'd0 : DEBOUNCE_CYCLES - 20'd1;
  // A zero cooldown still waits for one tick before allowing a new request.
  localparam logic [2:0] CD_LOAD =
    (COOLDOWN_TICKS == 3'd0) ? 3'd1 : COOLDOWN_TICKS;

  logic        syncMeta;
  logic        syncOut;
  logic        dbLevel;
  logic [19:0] dbCount;
  logic        pressEvt;

  stateT       state;
  stateT       stateNext;
  logic [2:0]  coolCnt;
  logic        latchPos;
  logic        launch;
  logic        coolDec;
  logic        posOk;
  logic        playing;

  assign posOk    = (player_x <= 4'd9) && (player_y <= 4'd9);
  assign playing  = (game_state == 2'd0);
  assign dbgState = state;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta <= 1'b0;
      syncOut  <= 1'b0;
    end else begin
      syncMeta <= btn_raw;
      syncOut  <= syncMeta;
    end
  end

  // Debounce: flip the level after a full run of mismatching cycles; a press pulse marks a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbLevel  <= 1'b0;
      dbCount  <= 20'd0;
      pressEvt <= 1'b0;
    end else begin
      pressEvt <= 1'b0;
      if (syncOut != dbLevel) begin
        if (dbCount >= DB_LIMIT) begin
          dbLevel  <= syncOut;
          dbCount  <= 20'd0;
          pressEvt <= syncOut;
        end else begin
          dbCount <= dbCount + 20'd1;
        end
      end else begin
        dbCount <= 20'd0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic. A tick in ARMED wins over game over, because the engine already took the bomb.
  always_comb begin
    stateNext = state;
    latchPos  = 1'b0;
    launch    = 1'b0;
    coolDec   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pressEvt && playing && posOk) begin
          stateNext = ARMED;
          latchPos  = 1'b1;
        end
      end
      ARMED: begin
        if (bomb_tick) begin
          stateNext = COOLDOWN;
          launch    = 1'b1;
        end else if (!playing) begin
          stateNext = IDLE;
        end
      end
      COOLDOWN: begin
        if (bomb_tick) begin
          coolDec = 1'b1;
          if (coolCnt <= 3'd1) begin
            stateNext = IDLE;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Registered outputs, the request position, the cooldown counter and the launch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bomb_v       <= 1'b0;
      busy         <= 1'b0;
      bomb_x       <= 4'd0;
      bomb_y       <= 4'd0;
      coolCnt      <= 3'd0;
      launch_count <= 8'd0;
    end else begin
      bomb_v <= (stateNext == ARMED);
      busy   <= (stateNext != IDLE);
      if (latchPos) begin
        bomb_x <= player_x;
        bomb_y <= player_y;
      end
      if (launch) begin
        coolCnt      <= CD_LOAD;
        launch_count <= launch_count + 8'd1;
      end else if (coolDec) begin
        coolCnt <= coolCnt - 3'd1;
      end
    end
  end

endmodule

// File: doc/bomb_launcher.md
BOMB_LAUNCHER -- requirements
Module: bomb_launcher

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd500000; number of consecutive stable clk cycles before the debounced button level changes.
REQ-002 Parameter COOLDOWN_TICKS, default 3'd4; number of bomb_tick strobes a player is locked out after a launch is accepted.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 btn_raw  input  1  raw, unsynchronised, bouncing player drop button; 1 = pressed.
REQ-006 bomb_tick  input  1  one-clk-cycle strobe marking the cycle in which the bomb-map engine samples bomb_v/x/y on its bombClk edge.
REQ-007 player_x, player_y  input  4 each  current player cell; valid range 0..9.
REQ-008 game_state  input  2  0 = playing; 1, 2 or 3 = game over.
REQ-009 bomb_v  output  1  bomb placement request to the engine; held high until sampled.
REQ-010 bomb_x, bomb_y  output  4 each  cell of the pending request; stable whenever bomb_v = 1.
REQ-011 busy  output  1  high in ARMED or COOLDOWN.
REQ-012 launch_count  output  8  number of requests sampled by the engine; wraps 255 -> 0.

Function
REQ-013 btn_raw SHALL pass through a 2-flop synchroniser before any other use.
REQ-014 The debounced level SHALL change only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears the counter.
REQ-015 A press event SHALL be a one-cycle pulse on the 0 -> 1 transition of the debounced level; the 1 -> 0 transition SHALL generate no event.
REQ-016 FSM states SHALL be IDLE, ARMED and COOLDOWN; the reset state is IDLE.
REQ-017 IDLE -> ARMED on the cycle after a press event with game_state == 0, player_x <= 9 and player_y <= 9; bomb_x and bomb_y SHALL latch player_x and player_y on that transition edge.
REQ-018 A press in IDLE with an out-of-range position or game_state != 0 SHALL be dropped and the FSM SHALL stay in IDLE.
REQ-019 bomb_v SHALL be 1 exactly while in ARMED, as a registered output.
REQ-020 ARMED with bomb_tick = 1 -> COOLDOWN on the next edge; on the same edge the cooldown counter loads COOLDOWN_TICKS and launch_count increments by 1.
REQ-021 A bomb_tick in the same cycle as the IDLE -> ARMED press SHALL NOT count as sampling; bomb_v first rises on the following cycle.
REQ-022 In COOLDOWN each bomb_tick SHALL decrement the counter; a tick with counter == 1 SHALL move the FSM to IDLE.
REQ-023 COOLDOWN_TICKS == 0 SHALL behave as 1.
REQ-024 Press events in ARMED or COOLDOWN SHALL be discarded, not queued.
REQ-025 game_state != 0 while in ARMED SHALL move the FSM to IDLE on the next edge with no launch_count increment; bomb_v falls on that edge.
REQ-026 game_state != 0 while in COOLDOWN SHALL NOT alter the countdown.
REQ-027 Changes to player_x and player_y while in ARMED SHALL NOT alter bomb_x and bomb_y.
REQ-028 bomb_x and bomb_y SHALL hold their last value outside ARMED.

Reset
REQ-029 On rst_n = 0, regardless of clk, SHALL apply: FSM = IDLE, bomb_v = 0, bomb_x = 0, bomb_y = 0, busy = 0, launch_count = 0, cooldown and debounce counters = 0, synchroniser flops and debounced level = 0.
REQ-030 rst_n asserted while in ARMED SHALL drop bomb_v immediately, asynchronously.
REQ-031 A button held through reset release SHALL produce a press only after debounce, that is DEBOUNCE_CYCLES after the synchronised level reads 1.

Verification
REQ-032 DEBOUNCE_CYCLES = 4, btn_raw toggling every 2 cycles for 20 cycles, then held at 1 -> exactly one press event; no press during the toggling.
REQ-033 Position (3,7), game_state = 0, press -> bomb_v = 1 with bomb_x = 3 and bomb_y = 7 from the next cycle; held across 5 tick-free cycles; falls the cycle after bomb_tick; launch_count = 1.
REQ-034 COOLDOWN_TICKS = 4, second press after 2 ticks -> ignored and busy = 1; busy falls the cycle after the 4th tick; a subsequent press is accepted.
REQ-035 Position (10,2) press -> no bomb_v and launch_count unchanged; position (9,9) press -> bomb_v with (9,9).
REQ-036 In ARMED, game_state set to 2 -> bomb_v = 0 next cycle, FSM = IDLE, launch_count unchanged.
REQ-037 rst_n pulled low mid-ARMED between clk edges -> bomb_v = 0 without waiting for a clk edge; all outputs equal their reset values.
